// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle of the decode
// stage, plus the register-file read port.
//   slave  : view used by decode_stage
//   master : view used by the surrounding fetch / regfile / execute logic
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_alucode;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_we;
  logic [31:0] out_br_target;
  logic [31:0] out_pc;
  logic        out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_alucode, out_op1,
           out_op2, out_store_data, out_rd, out_reg_we, out_br_target,
           out_pc, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_alucode, out_op1,
           out_op2, out_store_data, out_rd, out_reg_we, out_br_target,
           out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32IM decode. Turns one fetched instruction into
// the ALU operand bundle, with a one-bubble load-use interlock and flush from
// execute.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : decode_stage_if.slave (fetch in_*, regfile rs*, execute out_*,
//              flush)
module decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);
  localparam logic [5:0] ALU_NOP  = 6'd0,  ALU_ADD  = 6'd1,  ALU_SUB   = 6'd2,
                         ALU_SLT  = 6'd3,  ALU_SLTU = 6'd4,  ALU_XOR   = 6'd5,
                         ALU_OR   = 6'd6,  ALU_AND  = 6'd7,  ALU_SLL   = 6'd8,
                         ALU_SRL  = 6'd9,  ALU_SRA  = 6'd10, ALU_LUI   = 6'd11,
                         ALU_JAL  = 6'd12, ALU_JALR = 6'd13, ALU_BEQ   = 6'd14,
                         ALU_BNE  = 6'd15, ALU_BLT  = 6'd16, ALU_BGE   = 6'd17,
                         ALU_BLTU = 6'd18, ALU_BGEU = 6'd19, ALU_MUL   = 6'd20,
                         ALU_LB   = 6'd28, ALU_LH   = 6'd29, ALU_LW    = 6'd30,
                         ALU_LBU  = 6'd31, ALU_LHU  = 6'd32, ALU_SB    = 6'd33,
                         ALU_SH   = 6'd34, ALU_SW   = 6'd35;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6f,
                         OPC_JALR = 7'h67, OPC_BR = 7'h63, OPC_LD = 7'h03,
                         OPC_ST = 7'h23, OPC_OPI = 7'h13, OPC_OP = 7'h33,
                         OPC_FENCE = 7'h0f, OPC_SYS = 7'h73;

  typedef struct packed {
    logic [5:0]  alucode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic        illegal;
    logic        is_load;   // kept for the load-use check on the next instr
  } bundle_t;

  logic [31:0] ins, pc, r1v, r2v;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins   = bus.in_instr;
  assign pc    = bus.in_pc;
  assign r1v   = bus.rs1_data;
  assign r2v   = bus.rs2_data;
  assign opc   = ins[6:0];
  assign rd    = ins[11:7];
  assign f3    = ins[14:12];
  assign rs1   = ins[19:15];
  assign rs2   = ins[24:20];
  assign f7    = ins[31:25];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  assign bus.rs1_addr = rs1;
  assign bus.rs2_addr = rs2;

  // ---------------- combinational decode ----------------
  bundle_t dec;
  logic    use_rs1, use_rs2, wr_rd, ill;

  always_comb begin
    dec         = '0;
    dec.alucode = ALU_NOP;
    dec.pc      = pc;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    wr_rd       = 1'b0;
    ill         = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec.alucode = ALU_LUI;
        dec.op2     = imm_u;
        wr_rd       = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alucode = ALU_ADD;
        dec.op1     = pc;
        dec.op2     = imm_u;
        wr_rd       = 1'b1;
      end
      OPC_JAL: begin
        dec.alucode   = ALU_JAL;
        dec.op2       = pc;
        dec.br_target = pc + imm_j;
        wr_rd         = 1'b1;
      end
      OPC_JALR: begin
        dec.alucode   = ALU_JALR;
        dec.op1       = r1v;
        dec.op2       = pc;
        dec.br_target = (r1v + imm_i) & 32'hFFFF_FFFE;
        use_rs1       = 1'b1;
        wr_rd         = 1'b1;
        ill           = (f3 != 3'b000);
      end
      OPC_BR: begin
        dec.op1       = r1v;
        dec.op2       = r2v;
        dec.br_target = pc + imm_b;
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        case (f3)
          3'b000:  dec.alucode = ALU_BEQ;
          3'b001:  dec.alucode = ALU_BNE;
          3'b100:  dec.alucode = ALU_BLT;
          3'b101:  dec.alucode = ALU_BGE;
          3'b110:  dec.alucode = ALU_BLTU;
          3'b111:  dec.alucode = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LD: begin
        dec.op1     = r1v;
        dec.op2     = imm_i;
        dec.is_load = 1'b1;
        use_rs1     = 1'b1;
        wr_rd       = 1'b1;
        case (f3)
          3'b000:  dec.alucode = ALU_LB;
          3'b001:  dec.alucode = ALU_LH;
          3'b010:  dec.alucode = ALU_LW;
          3'b100:  dec.alucode = ALU_LBU;
          3'b101:  dec.alucode = ALU_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPC_ST: begin
        dec.op1        = r1v;
        dec.op2        = imm_s;
        dec.store_data = r2v;
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        case (f3)
          3'b000:  dec.alucode = ALU_SB;
          3'b001:  dec.alucode = ALU_SH;
          3'b010:  dec.alucode = ALU_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_OPI: begin
        dec.op1 = r1v;
        dec.op2 = imm_i;
        use_rs1 = 1'b1;
        wr_rd   = 1'b1;
        case (f3)
          3'b000: dec.alucode = ALU_ADD;
          3'b010: dec.alucode = ALU_SLT;
          3'b011: dec.alucode = ALU_SLTU;
          3'b100: dec.alucode = ALU_XOR;
          3'b110: dec.alucode = ALU_OR;
          3'b111: dec.alucode = ALU_AND;
          3'b001: begin
            dec.op2     = {27'b0, ins[24:20]};
            dec.alucode = ALU_SLL;
            ill         = (f7 != 7'h00);
          end
          default: begin  // 3'b101
            dec.op2 = {27'b0, ins[24:20]};
            if (f7 == 7'h00)      dec.alucode = ALU_SRL;
            else if (f7 == 7'h20) dec.alucode = ALU_SRA;
            else                  ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.op1 = r1v;
        dec.op2 = r2v;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        wr_rd   = 1'b1;
        case (f7)
          7'h00: begin
            case (f3)
              3'b000:  dec.alucode = ALU_ADD;
              3'b001:  dec.alucode = ALU_SLL;
              3'b010:  dec.alucode = ALU_SLT;
              3'b011:  dec.alucode = ALU_SLTU;
              3'b100:  dec.alucode = ALU_XOR;
              3'b101:  dec.alucode = ALU_SRL;
              3'b110:  dec.alucode = ALU_OR;
              default: dec.alucode = ALU_AND;
            endcase
          end
          7'h20: begin
            if (f3 == 3'b000)      dec.alucode = ALU_SUB;
            else if (f3 == 3'b101) dec.alucode = ALU_SRA;
            else                   ill = 1'b1;
          end
          // M extension codes are laid out in funct3 order
          7'h01:   dec.alucode = ALU_MUL + {3'b0, f3};
          default: ill = 1'b1;
        endcase
      end
      OPC_FENCE: ill = (f3 != 3'b000);
      // only ECALL / EBREAK are accepted; CSR and xRET forms trap
      OPC_SYS:   ill = !(ins[31:7] == 25'h0 || ins[31:7] == 25'h0002000);
      default:   ill = 1'b1;
    endcase

    if (ill) begin
      dec         = '0;
      dec.alucode = ALU_NOP;
      dec.pc      = pc;
      dec.illegal = 1'b1;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end else if (wr_rd) begin
      dec.rd     = rd;
      dec.reg_we = (rd != 5'd0);
    end
  end

  // ---------------- pipeline register control ----------------
  bundle_t bun_d, bun_q;
  logic    valid_d, valid_q;
  logic    adv, hazard;

  assign adv = !valid_q || bus.out_ready;

  // The load in the register leaves this cycle, but its data is not yet
  // available to a consumer being decoded now: insert one bubble.
  assign hazard = valid_q && bus.out_ready && bun_q.is_load && (bun_q.rd != 5'd0)
               && bus.in_valid
               && ((use_rs1 && rs1 == bun_q.rd) || (use_rs2 && rs2 == bun_q.rd));

  assign bus.in_ready = bus.flush || (adv && !hazard);

  always_comb begin
    valid_d = valid_q;
    bun_d   = bun_q;
    if (bus.flush) begin
      valid_d = 1'b0;       // presented instr is consumed and dropped
    end else if (adv) begin
      valid_d = bus.in_valid && !hazard;
      if (bus.in_valid && !hazard) bun_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      bun_q         <= '0;
      bun_q.alucode <= ALU_NOP;
      bun_q.pc      <= RESET_PC;
    end else begin
      valid_q <= valid_d;
      bun_q   <= bun_d;
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_alucode    = bun_q.alucode;
  assign bus.out_op1        = bun_q.op1;
  assign bus.out_op2        = bun_q.op2;
  assign bus.out_store_data = bun_q.store_data;
  assign bus.out_rd         = bun_q.rd;
  assign bus.out_reg_we     = bun_q.reg_we;
  assign bus.out_br_target  = bun_q.br_target;
  assign bus.out_pc         = bun_q.pc;
  assign bus.out_illegal    = bun_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: builds instructions from (kind, fields, immediate value),
// predicts the bundle from those fields and tracks the stage register with a
// cycle model of the handshake rules.
module tb_decode_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [5:0] A_NOP = 0, A_ADD = 1, A_SUB = 2, A_SLT = 3, A_SLTU = 4,
    A_XOR = 5, A_OR = 6, A_AND = 7, A_SLL = 8, A_SRL = 9, A_SRA = 10, A_LUI = 11,
    A_JAL = 12, A_JALR = 13, A_BEQ = 14, A_BNE = 15, A_BLT = 16, A_BGE = 17,
    A_BLTU = 18, A_BGEU = 19, A_MUL = 20, A_MULHU = 23, A_LB = 28, A_LH = 29,
    A_LW = 30, A_LBU = 31, A_LHU = 32, A_SB = 33, A_SH = 34, A_SW = 35;

  localparam int K_LUI = 0, K_AUIPC = 1, K_JAL = 2, K_JALR = 3, K_BR = 4, K_LD = 5,
                 K_ST = 6, K_OPI = 7, K_OP = 8, K_MD = 9, K_SYS = 10, K_ILL = 11;
  localparam int NK = 12;
  localparam int NSUB [12] = '{1, 1, 1, 1, 6, 5, 3, 9, 10, 8, 3, 10};

  localparam logic [2:0] BR_F3 [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [5:0] BR_A  [6]  = '{A_BEQ, A_BNE, A_BLT, A_BGE, A_BLTU, A_BGEU};
  localparam logic [2:0] LD_F3 [5]  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  localparam logic [5:0] LD_A  [5]  = '{A_LB, A_LH, A_LW, A_LBU, A_LHU};
  localparam logic [5:0] ST_A  [3]  = '{A_SB, A_SH, A_SW};
  localparam logic [2:0] OPI_F3 [9] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd5, 3'd5};
  localparam logic [5:0] OPI_A [9]  = '{A_ADD, A_SLT, A_SLTU, A_XOR, A_OR, A_AND, A_SLL, A_SRL, A_SRA};
  localparam logic [2:0] OP_F3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  localparam logic [5:0] OP_A  [10] = '{A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND};

  typedef struct packed {
    logic [5:0]  alu;
    logic [31:0] op1, op2, sdata;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] tgt, pc;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_if dif ();
  decode_stage #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(dif.slave));

  logic [31:0] regs [32];
  assign dif.rs1_data = regs[dif.rs1_addr];
  assign dif.rs2_data = regs[dif.rs2_addr];

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // currently presented instruction and its prediction
  logic [31:0] cur_instr, cur_pc;
  exp_t        cur_e;
  logic        cur_ld, cur_u1, cur_u2;
  logic [4:0]  cur_rs1, cur_rs2;

  // model of the stage register
  exp_t m_b;
  logic m_v, m_ld;
  logic acc, obs_irdy;

  task automatic gen(input int k, input int s, input logic [4:0] rd, input logic [4:0] a,
                     input logic [4:0] b, input int imm, input logic [31:0] pc);
    logic [31:0] iv, r1v, r2v, ins;
    exp_t e;
    logic wr;
    iv = imm; r1v = regs[a]; r2v = regs[b];
    e = '0; e.alu = A_NOP; e.pc = pc; ins = '0; wr = 1'b0;
    cur_ld = 1'b0; cur_u1 = 1'b0; cur_u2 = 1'b0;
    case (k)
      K_LUI:   begin ins = {iv[19:0], rd, 7'h37}; e.alu = A_LUI; e.op2 = iv << 12; wr = 1; end
      K_AUIPC: begin ins = {iv[19:0], rd, 7'h17}; e.alu = A_ADD; e.op1 = pc; e.op2 = iv << 12; wr = 1; end
      K_JAL: begin
        ins = {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'h6f};
        e.alu = A_JAL; e.op2 = pc; e.tgt = pc + iv; wr = 1;
      end
      K_JALR: begin
        ins = {iv[11:0], a, 3'd0, rd, 7'h67};
        e.alu = A_JALR; e.op1 = r1v; e.op2 = pc; e.tgt = (r1v + iv) & ~32'd1; wr = 1; cur_u1 = 1;
      end
      K_BR: begin
        ins = {iv[12], iv[10:5], b, a, BR_F3[s], iv[4:1], iv[11], 7'h63};
        e.alu = BR_A[s]; e.op1 = r1v; e.op2 = r2v; e.tgt = pc + iv; cur_u1 = 1; cur_u2 = 1;
      end
      K_LD: begin
        ins = {iv[11:0], a, LD_F3[s], rd, 7'h03};
        e.alu = LD_A[s]; e.op1 = r1v; e.op2 = iv; wr = 1; cur_ld = 1; cur_u1 = 1;
      end
      K_ST: begin
        ins = {iv[11:5], b, a, 3'(s), iv[4:0], 7'h23};
        e.alu = ST_A[s]; e.op1 = r1v; e.op2 = iv; e.sdata = r2v; cur_u1 = 1; cur_u2 = 1;
      end
      K_OPI: begin
        if (s < 6) ins = {iv[11:0], a, OPI_F3[s], rd, 7'h13};
        else       ins = {(s == 8) ? 7'h20 : 7'h00, iv[4:0], a, OPI_F3[s], rd, 7'h13};
        e.alu = OPI_A[s]; e.op1 = r1v; e.op2 = iv; wr = 1; cur_u1 = 1;
      end
      K_OP: begin
        ins = {(s == 1 || s == 7) ? 7'h20 : 7'h00, b, a, OP_F3[s], rd, 7'h33};
        e.alu = OP_A[s]; e.op1 = r1v; e.op2 = r2v; wr = 1; cur_u1 = 1; cur_u2 = 1;
      end
      K_MD: begin
        ins = {7'h01, b, a, 3'(s), rd, 7'h33};
        e.alu = A_MUL + 6'(s); e.op1 = r1v; e.op2 = r2v; wr = 1; cur_u1 = 1; cur_u2 = 1;
      end
      K_SYS: begin
        if (s == 0)      ins = {iv[11:0], 13'd0, 7'h0f};
        else if (s == 1) ins = 32'h0000_0073;
        else             ins = 32'h0010_0073;
      end
      default: begin
        e.ill = 1'b1;
        case (s)
          0: ins = {iv[24:0], iv[25] ? 7'h7f : 7'h07};
          1: ins = {7'h00, b, a, 3'b010, 5'd0, 7'h63};
          2: ins = {iv[11:0], a, 3'b011, rd, 7'h03};
          3: ins = {7'h00, b, a, 3'b100, 5'd0, 7'h23};
          4: ins = {7'h20, iv[4:0], a, 3'b001, rd, 7'h13};
          5: ins = {7'h01, iv[4:0], a, 3'b101, rd, 7'h13};
          6: ins = {7'h7f, b, a, 3'b000, rd, 7'h33};
          7: ins = {7'h20, b, a, 3'b001, rd, 7'h33};
          8: ins = {iv[11:0], a, 3'b001, rd, 7'h67};
          default: ins = {12'h300, a, 3'b001, rd, 7'h73};
        endcase
      end
    endcase
    if (wr) begin e.rd = rd; e.we = (rd != 0); end
    cur_instr = ins; cur_pc = pc; cur_e = e; cur_rs1 = a; cur_rs2 = b;
  endtask

  function automatic int rand_imm(input int k, input int s);
    case (k)
      K_LUI, K_AUIPC: return int'($urandom_range(0, 1048575));
      K_JAL:          return int'($urandom_range(0, 1048575)) * 2 - 1048576;
      K_BR:           return int'($urandom_range(0, 4095)) * 2 - 4096;
      K_OPI:          return (s >= 6) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
      K_ILL:          return int'($urandom);
      default:        return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic cmp_out(input string t, input exp_t e);
    chk({t, ".alu"},  32'(dif.out_alucode), 32'(e.alu));
    chk({t, ".op1"},  dif.out_op1, e.op1);
    chk({t, ".op2"},  dif.out_op2, e.op2);
    chk({t, ".sd"},   dif.out_store_data, e.sdata);
    chk({t, ".rd"},   32'(dif.out_rd), 32'(e.rd));
    chk({t, ".we"},   32'(dif.out_reg_we), 32'(e.we));
    chk({t, ".tgt"},  dif.out_br_target, e.tgt);
    chk({t, ".pc"},   dif.out_pc, e.pc);
    chk({t, ".ill"},  32'(dif.out_illegal), 32'(e.ill));
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic r);
    logic adv, hz, irdy;
    logic [31:0] t;
    rst = r; dif.in_valid = iv; dif.in_instr = cur_instr; dif.in_pc = cur_pc;
    dif.out_ready = ordy; dif.flush = fl;
    #1;
    t = cur_instr;
    adv  = !m_v || ordy;
    hz   = m_v && ordy && m_ld && (m_b.rd != 0) && iv &&
           ((cur_u1 && cur_rs1 == m_b.rd) || (cur_u2 && cur_rs2 == m_b.rd));
    irdy = fl || (adv && !hz);
    obs_irdy = dif.in_ready;
    chk("rs1_addr", 32'(dif.rs1_addr), 32'(t[19:15]));
    chk("rs2_addr", 32'(dif.rs2_addr), 32'(t[24:20]));
    if (!r) chk("in_ready", 32'(dif.in_ready), 32'(irdy));
    acc = !r && iv && irdy;
    if (r) begin
      m_v = 1'b0; m_ld = 1'b0; m_b = '0; m_b.alu = A_NOP; m_b.pc = RESET_PC;
    end else if (fl) begin
      m_v = 1'b0;
    end else if (adv) begin
      if (hz || !iv) m_v = 1'b0;
      else begin m_v = 1'b1; m_b = cur_e; m_ld = cur_ld; end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 32'(dif.out_valid), 32'(m_v));
    if (m_v || r) cmp_out(r ? "rst" : "out", m_b);
  endtask

  function automatic logic [173:0] snap();
    return {dif.out_valid, dif.out_alucode, dif.out_op1, dif.out_op2, dif.out_store_data,
            dif.out_rd, dif.out_reg_we, dif.out_br_target, dif.out_pc, dif.out_illegal};
  endfunction

  logic [31:0] pc_ctr;
  logic [4:0]  prev_rd;
  logic [173:0] sv;

  task automatic new_rand();
    int k, s;
    logic [4:0] d, a, b;
    k = $urandom_range(0, NK - 1);
    if ($urandom_range(0, 3) == 0) k = K_LD;
    s = $urandom_range(0, NSUB[k] - 1);
    d = 5'($urandom); a = 5'($urandom); b = 5'($urandom);
    if ($urandom_range(0, 1) == 1) a = prev_rd;
    if ($urandom_range(0, 2) == 0) b = prev_rd;
    prev_rd = d;
    pc_ctr += 4;
    gen(k, s, d, a, b, rand_imm(k, s), pc_ctr);
  endtask

  initial begin
    regs[0] = '0; regs[1] = 32'd5; regs[2] = 32'd5;
    for (int i = 3; i < 32; i++) regs[i] = $urandom;
    m_v = 1'b0; m_ld = 1'b0; m_b = '0; acc = 1'b0; obs_irdy = 1'b0;
    pc_ctr = 32'h1000; prev_rd = '0;
    gen(K_SYS, 0, 0, 0, 0, 0, 32'h0);

    // reset state, then in_ready high once reset is released
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_irdy", 32'(obs_irdy), 32'd1);
    chk("post_rst_pc", dif.out_pc, RESET_PC);

    // addi x1,x0,-1 @0x100
    gen(K_OPI, 0, 5'd1, 5'd0, 5'd0, -1, 32'h100);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("addi.alu", 32'(dif.out_alucode), 32'(A_ADD));
    chk("addi.op2", dif.out_op2, 32'hFFFF_FFFF);
    chk("addi.rd_we", {dif.out_rd, dif.out_reg_we}, {5'd1, 1'b1});

    // beq x1,x2,-8 @0x200 with x1 = x2 = 5
    gen(K_BR, 0, 5'd0, 5'd1, 5'd2, -8, 32'h200);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("beq.alu", 32'(dif.out_alucode), 32'(A_BEQ));
    chk("beq.ops", {dif.out_op1, dif.out_op2}, {32'd5, 32'd5});
    chk("beq.tgt", dif.out_br_target, 32'h1F8);
    chk("beq.we", 32'(dif.out_reg_we), 32'd0);

    // lw x5,0(x2) ; add x6,x5,x1 -> one bubble
    gen(K_LD, 2, 5'd5, 5'd2, 5'd0, 0, 32'h300);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    gen(K_OP, 0, 5'd6, 5'd5, 5'd1, 0, 32'h304);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu.irdy", 32'(obs_irdy), 32'd0);
    chk("lu.bubble", 32'(dif.out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu.issue", {dif.out_valid, dif.out_pc}, {1'b1, 32'h304});
    // same with rd = x0: no bubble
    gen(K_LD, 2, 5'd0, 5'd2, 5'd0, 0, 32'h310);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    gen(K_OP, 0, 5'd6, 5'd0, 5'd1, 0, 32'h314);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("lu0.irdy", 32'(obs_irdy), 32'd1);
    chk("lu0.issue", {dif.out_valid, dif.out_pc}, {1'b1, 32'h314});

    // stall 3 cycles
    gen(K_MD, 3, 5'd3, 5'd4, 5'd5, 0, 32'h400);   // mulhu x3,x4,x5
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("mulhu.alu", 32'(dif.out_alucode), 32'(A_MULHU));
    sv = snap();
    gen(K_OPI, 0, 5'd7, 5'd1, 5'd0, 12, 32'h404);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("stall.irdy", 32'(obs_irdy), 32'd0);
      chk("stall.stable", 32'(snap() == sv), 32'd1);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("stall.next", dif.out_pc, 32'h404);

    // flush with jal in the register and sub presented
    gen(K_JAL, 0, 5'd1, 5'd0, 5'd0, 16, 32'h500);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    gen(K_OP, 1, 5'd8, 5'd3, 5'd4, 0, 32'h504);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush.v", 32'(dif.out_valid), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("flush.drop", 32'(dif.out_valid), 32'd0);

    // slli with funct7 0100000
    gen(K_ILL, 4, 5'd1, 5'd1, 5'd0, 3, 32'h600);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("slli_bad", {dif.out_illegal, dif.out_alucode, dif.out_reg_we}, {1'b1, A_NOP, 1'b0});

    // rst mid-stall
    gen(K_OPI, 0, 5'd9, 5'd2, 5'd0, 7, 32'h700);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_stall", {dif.out_valid, dif.out_pc}, {1'b0, RESET_PC});
    // rst mid-hazard leaves no residual bubble
    gen(K_LD, 2, 5'd5, 5'd2, 5'd0, 0, 32'h800);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    gen(K_OP, 0, 5'd6, 5'd5, 5'd1, 0, 32'h804);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_hz.issue", {dif.out_valid, dif.out_pc}, {1'b1, 32'h804});

    // randomized traffic
    new_rand();
    for (int c = 0; c < 4000; c++) begin
      if (acc) new_rand();
      step($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
